// File: rtl/strng_postproc.sv
// Post-processor for the STR TRNG core: XOR-folds DECIM raw samples per folded word,
// runs a repetition-count health test on each fold and packs folds into OUT_W-bit words.
module strng_postproc #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 32,
  parameter int DECIM     = 4,
  parameter int WARMUP    = 64,
  parameter int RCT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [IN_W-1:0]  rnd_data,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail,
  output logic             ovf
);

  localparam int SLOTS = OUT_W / IN_W;
  localparam int DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PCW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              warm_s;
  logic              run_s;
  logic              fail_s;

  logic [15:0]       wcnt_r;
  logic [DCW-1:0]    dcnt_r;
  logic [IN_W-1:0]   acc_r;
  logic [IN_W-1:0]   fold_s;
  logic              fold_strobe_s;

  logic [IN_W-1:0]   prev_r;
  logic [7:0]        rcnt_r;
  logic [7:0]        rcnt_nxt_s;
  logic              rct_first_r;
  logic              trip_s;

  logic [IN_W-1:0]   pend_r;
  logic              pend_vld_r;
  logic [OUT_W-1:0]  pack_r;
  logic [OUT_W-1:0]  pack_nxt_s;
  logic [PCW-1:0]    pcnt_r;
  logic              pack_en_s;
  logic              word_done_s;

  logic [OUT_W-1:0]  out_data_r;
  logic              out_valid_r;
  logic              health_fail_r;
  logic              ovf_r;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; en=0 always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (!en) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = ST_WARMUP;
        ST_WARMUP: begin
          if (wcnt_r == 16'(WARMUP - 1)) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_WARMUP;
          end
        end
        ST_RUN: begin
          if (trip_s) begin
            state_nxt_s = ST_FAIL;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FAIL:   state_nxt_s = ST_FAIL;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State decode into datapath controls
  always_comb begin
    warm_s = 1'b0;
    run_s  = 1'b0;
    fail_s = 1'b0;
    case (state_r)
      ST_WARMUP: warm_s = 1'b1;
      ST_RUN:    run_s  = 1'b1;
      ST_FAIL:   fail_s = 1'b1;
      default: begin
        warm_s = 1'b0;
        run_s  = 1'b0;
        fail_s = 1'b0;
      end
    endcase
  end

  assign fold_s        = acc_r ^ rnd_data;
  assign fold_strobe_s = run_s && (dcnt_r == DCW'(DECIM - 1));

  // Repetition count as it would stand after this fold
  always_comb begin
    if (rct_first_r || (fold_s != prev_r)) begin
      rcnt_nxt_s = 8'd1;
    end else begin
      rcnt_nxt_s = rcnt_r + 8'd1;
    end
  end

  assign trip_s = fold_strobe_s && (rcnt_nxt_s == 8'(RCT_LIMIT));

  // Warmup count, XOR folding and repetition-count history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt_r      <= 16'd0;
      dcnt_r      <= {DCW{1'b0}};
      acc_r       <= {IN_W{1'b0}};
      prev_r      <= {IN_W{1'b0}};
      rcnt_r      <= 8'd0;
      rct_first_r <= 1'b1;
      pend_r      <= {IN_W{1'b0}};
      pend_vld_r  <= 1'b0;
    end else if (!en) begin
      wcnt_r      <= 16'd0;
      dcnt_r      <= {DCW{1'b0}};
      acc_r       <= {IN_W{1'b0}};
      prev_r      <= {IN_W{1'b0}};
      rcnt_r      <= 8'd0;
      rct_first_r <= 1'b1;
      pend_r      <= {IN_W{1'b0}};
      pend_vld_r  <= 1'b0;
    end else begin
      if (warm_s) begin
        wcnt_r <= wcnt_r + 16'd1;
      end else begin
        wcnt_r <= 16'd0;
      end
      if (fold_strobe_s) begin
        acc_r       <= {IN_W{1'b0}};
        dcnt_r      <= {DCW{1'b0}};
        prev_r      <= fold_s;
        rcnt_r      <= rcnt_nxt_s;
        rct_first_r <= 1'b0;
        pend_r      <= fold_s;
        pend_vld_r  <= !trip_s;
      end else if (run_s) begin
        acc_r      <= fold_s;
        dcnt_r     <= dcnt_r + DCW'(1'b1);
        pend_vld_r <= 1'b0;
      end else begin
        pend_vld_r <= 1'b0;
      end
    end
  end

  // Folds are packed one edge after they are produced; a tripping fold never reaches here
  assign pack_en_s   = run_s && pend_vld_r && !trip_s;
  assign word_done_s = pack_en_s && (pcnt_r == PCW'(SLOTS - 1));

  // Packer contents with the pending fold dropped into slot pcnt
  always_comb begin
    pack_nxt_s = pack_r;
    for (int i = 0; i < SLOTS; i++) begin
      if (pcnt_r == PCW'(i)) begin
        pack_nxt_s[i*IN_W +: IN_W] = pend_r;
      end else begin
        pack_nxt_s[i*IN_W +: IN_W] = pack_r[i*IN_W +: IN_W];
      end
    end
  end

  // Packer slot counter and partial word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_r <= {OUT_W{1'b0}};
      pcnt_r <= {PCW{1'b0}};
    end else if (!en) begin
      pack_r <= {OUT_W{1'b0}};
      pcnt_r <= {PCW{1'b0}};
    end else if (pack_en_s) begin
      pack_r <= pack_nxt_s;
      if (word_done_s) begin
        pcnt_r <= {PCW{1'b0}};
      end else begin
        pcnt_r <= pcnt_r + PCW'(1'b1);
      end
    end else begin
      pack_r <= pack_r;
      pcnt_r <= pcnt_r;
    end
  end

  // Output handshake register, health and overflow flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data_r    <= {OUT_W{1'b0}};
      out_valid_r   <= 1'b0;
      health_fail_r <= 1'b0;
      ovf_r         <= 1'b0;
    end else if (!en) begin
      out_valid_r   <= 1'b0;
      health_fail_r <= 1'b0;
      ovf_r         <= 1'b0;
    end else if (trip_s || fail_s) begin
      out_valid_r   <= 1'b0;
      health_fail_r <= 1'b1;
    end else if (word_done_s) begin
      if (!out_valid_r || out_ready) begin
        out_data_r  <= pack_nxt_s;
        out_valid_r <= 1'b1;
      end else begin
        ovf_r <= 1'b1;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign health_fail = health_fail_r;
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_strng_postproc.sv
// Scoreboard bench for strng_postproc: a queue-based reference model predicts every
// accepted word and the status flags; a negedge monitor compares against the DUT.
module tb_strng_postproc;

  localparam int IN_W      = 8;
  localparam int OUT_W     = 16;
  localparam int DECIM     = 4;
  localparam int WARMUP    = 6;
  localparam int RCT_LIMIT = 4;
  localparam int SLOTS     = OUT_W / IN_W;

  logic             clk;
  logic             rstn;
  logic             en;
  logic [IN_W-1:0]  rnd_data;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             health_fail;
  logic             ovf;

  strng_postproc #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DECIM(DECIM), .WARMUP(WARMUP), .RCT_LIMIT(RCT_LIMIT)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .rnd_data(rnd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .health_fail(health_fail), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  int en_edge  = 0;
  int words_seen = 0;
  bit lat_armed = 0;
  bit lat_seen  = 0;
  bit mon_on    = 0;

  // reference model state
  bit              m_active, m_failed, m_first, m_valid, m_hf, m_ovf;
  int              m_warm, m_runlen;
  logic [IN_W-1:0] m_prev;
  logic [IN_W-1:0] m_samp[$];
  logic [IN_W-1:0] m_pend[$];
  logic [IN_W-1:0] m_slots[$];
  logic [OUT_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_clear();
    m_active = 0; m_failed = 0; m_first = 1; m_valid = 0; m_hf = 0; m_ovf = 0;
    m_warm = 0; m_runlen = 0; m_prev = '0;
    m_samp.delete(); m_pend.delete(); m_slots.delete(); exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs applied before it
  task automatic model_step();
    bit consumed, have_word, tripped;
    logic [OUT_W-1:0] word;
    logic [IN_W-1:0] fold;
    edge_cnt++;
    if (!rstn || !en) begin model_clear(); return; end
    if (!m_active) begin m_active = 1; m_warm = 0; return; end
    if (m_failed) return;
    if (m_warm < WARMUP) begin m_warm++; return; end
    consumed  = m_valid && out_ready;
    have_word = 0;
    word      = '0;
    if (m_pend.size() > 0) begin
      m_slots.push_back(m_pend.pop_front());
      if (m_slots.size() == SLOTS) begin
        for (int i = 0; i < SLOTS; i++) word[i*IN_W +: IN_W] = m_slots[i];
        m_slots.delete();
        have_word = 1;
      end
    end
    tripped = 0;
    m_samp.push_back(rnd_data);
    if (m_samp.size() == DECIM) begin
      fold = '0;
      foreach (m_samp[i]) fold ^= m_samp[i];
      m_samp.delete();
      if (m_first || fold != m_prev) m_runlen = 1;
      else m_runlen++;
      m_prev  = fold;
      m_first = 0;
      if (m_runlen >= RCT_LIMIT) tripped = 1;
      else m_pend.push_back(fold);
    end
    if (tripped) begin
      m_failed = 1; m_hf = 1; m_valid = 0;
      exp_q.delete(); m_slots.delete();
      return;
    end
    if (have_word) begin
      if (!m_valid || consumed) begin exp_q.push_back(word); m_valid = 1; end
      else m_ovf = 1;
    end else if (consumed) begin
      m_valid = 0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then update the model
  task automatic cyc(input logic e, input logic [IN_W-1:0] d, input logic r);
    en = e; rnd_data = d; out_ready = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_rst();
    rstn = 1'b0;
    model_clear();
    #2;
    chk("async_reset_outputs", {13'd0, out_data, out_valid, health_fail, ovf}, 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    rstn = 1'b1;
  endtask

  task automatic enable_and_warm(input logic [IN_W-1:0] d);
    cyc(1'b0, d, 1'b1);
    cyc(1'b1, d, 1'b1);
    en_edge = edge_cnt;
    for (int i = 0; i < WARMUP; i++) cyc(1'b1, d, 1'b1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [OUT_W-1:0] w;
    if (mon_on && rstn) begin
      chk("flags{valid,hf,ovf}", {29'd0, out_valid, health_fail, ovf}, {29'd0, m_valid, m_hf, m_ovf});
      if (lat_armed && out_valid) begin
        chk("first_valid_latency", 32'(edge_cnt - en_edge), 32'(WARMUP + DECIM * SLOTS + 1));
        lat_armed = 0;
        lat_seen  = 1;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL word: got %0h with no word expected (t=%0t)", out_data, $time);
        end else begin
          w = exp_q.pop_front();
          words_seen++;
          if (out_data === w) n_pass++;
          else $display("FAIL word: got %0h expected %0h (t=%0t)", out_data, w, $time);
        end
      end
    end
  end

  logic [IN_W-1:0] seq_a[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'hFF, 8'hFF, 8'h00, 8'h00};
  logic [IN_W-1:0] seq_b[16] = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00,
                                 8'h33, 8'h00, 8'h00, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00};

  initial begin
    rstn = 1'b0; en = 1'b0; rnd_data = '0; out_ready = 1'b0;
    model_clear();
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    rstn = 1'b1;
    #1;
    chk("reset_state", {13'd0, out_data, out_valid, health_fail, ovf}, 32'd0);
    mon_on = 1;

    // fold of 01,02,04,08 then FF,FF,00,00; warmup samples must not leak in
    enable_and_warm(8'hEE);
    lat_armed = 1;
    foreach (seq_a[i]) cyc(1'b1, seq_a[i], 1'b1);
    cyc(1'b1, 8'h5A, 1'b1);
    @(negedge clk); #1;
    chk("fold_word_0x000F", {16'd0, out_data}, 32'h0000_000F);
    chk("latency_seen", {31'd0, lat_seen}, 32'd1);
    lat_armed = 0;

    // constant input trips the repetition-count test on the 16th sample
    enable_and_warm(8'hAA);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'hAA, 1'b1);
    @(negedge clk); #1;
    chk("rct_trip{hf,valid}", {30'd0, health_fail, out_valid}, 32'd2);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hAA, 1'b1);
    chk("hf_sticky", {31'd0, health_fail}, 32'd1);
    cyc(1'b0, 8'hAA, 1'b1);
    chk("hf_cleared_by_en", {31'd0, health_fail}, 32'd0);

    // backpressure: first word held, second dropped
    enable_and_warm(8'h77);
    foreach (seq_b[i]) cyc(1'b1, seq_b[i], 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    @(negedge clk); #1;
    chk("held_word", {16'd0, out_data}, 32'h0000_2211);
    chk("ovf_set{ovf,valid}", {30'd0, ovf, out_valid}, 32'd3);
    cyc(1'b1, 8'h00, 1'b1);
    @(negedge clk); #1;
    chk("valid_after_accept", {31'd0, out_valid}, 32'd0);

    // mid-word async reset, then mid-word en drop; later words built from new samples only
    enable_and_warm(8'h3C);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 1), 1'b1);
    pulse_rst();
    enable_and_warm(8'h3C);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h90, 1'b1);
    cyc(1'b0, 8'h90, 1'b1);
    chk("en_drop_clears", {29'd0, out_valid, health_fail, ovf}, 32'd0);
    enable_and_warm(8'h3C);
    for (int i = 0; i < DECIM * SLOTS + 2; i++) cyc(1'b1, 8'($urandom), 1'b1);

    // randomized traffic: mixed entropy, random backpressure, en drops, resets
    for (int n = 0; n < 3000; n++) begin
      logic [IN_W-1:0] d;
      logic e;
      if ((n / 500) % 2 == 1) d = 8'($urandom_range(0, 1));
      else d = 8'($urandom);
      e = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 399) == 0) pulse_rst();
      else cyc(e, d, ($urandom_range(0, 9) < 7));
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("words_observed", {31'd0, (words_seen > 20)}, 32'd1);

    mon_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
